// File: rtl/utim64_master_if.sv
// rtl/utim64_master_if.sv - command, completion and timer request/response bundle for utim64_master
interface utim64_master_if;
  logic        iCMD_VALID;
  logic        oCMD_BUSY;
  logic [1:0]  iCMD_OP;
  logic [1:0]  iCMD_CH;
  logic [3:0]  iCMD_CONF;
  logic [63:0] iCMD_DATA;
  logic        oRSP_VALID;
  logic        oRSP_ERR;
  logic [63:0] oRSP_DATA;
  logic        oREQ_VALID;
  logic        iREQ_BUSY;
  logic        oREQ_RW;
  logic [3:0]  oREQ_ADDR;
  logic [31:0] oREQ_DATA;
  logic        iREQ_VALID;
  logic [31:0] iREQ_DATA;

  modport master (
    input  iCMD_VALID, iCMD_OP, iCMD_CH, iCMD_CONF, iCMD_DATA,
    output oCMD_BUSY, oRSP_VALID, oRSP_ERR, oRSP_DATA,
    output oREQ_VALID, oREQ_RW, oREQ_ADDR, oREQ_DATA,
    input  iREQ_BUSY, iREQ_VALID, iREQ_DATA
  );

  modport slave (
    output iCMD_VALID, iCMD_OP, iCMD_CH, iCMD_CONF, iCMD_DATA,
    input  oCMD_BUSY, oRSP_VALID, oRSP_ERR, oRSP_DATA,
    input  oREQ_VALID, oREQ_RW, oREQ_ADDR, oREQ_DATA,
    output iREQ_BUSY, iREQ_VALID, iREQ_DATA
  );
endinterface

// File: rtl/utim64_master.sv
// rtl/utim64_master.sv - 64-bit timer command master issuing 32-bit register beats
// Optional WAIT timeout enabled by defining UTIM64_MASTER_TIMEOUT_EN.
module utim64_master (
  input logic             iTIMER_CLOCK,
  input logic             inRESET,
  utim64_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, ch_q;
  logic [3:0]  conf_q;
  logic [63:0] data_q;
  logic [1:0]  beat_q;
  logic [1:0]  outst_q, outst_d;
  logic        rd_idx_q;
  logic [63:0] acc_q;
  logic [63:0] rsp_data_q;

  logic        beat_rw, beat_last;
  logic [3:0]  beat_addr;
  logic [31:0] beat_data;
  logic        issue, rsp_take, timeout;

  always_comb begin
    beat_rw   = 1'b1;
    beat_addr = 4'h0;
    beat_data = 32'h0;
    beat_last = 1'b0;
    case (op_q)
      2'd0: case (beat_q)
        2'd0:    begin beat_addr = 4'h1; beat_data = data_q[31:0];  end
        2'd1:    begin beat_addr = 4'h2; beat_data = data_q[63:32]; end
        default: begin beat_addr = 4'h0; beat_data = {31'b0, conf_q[0]}; beat_last = 1'b1; end
      endcase
      2'd1: case (beat_q)
        2'd0:    begin beat_addr = 4'h3 + {1'b0, ch_q, 1'b0}; beat_data = data_q[31:0];  end
        2'd1:    begin beat_addr = 4'h4 + {1'b0, ch_q, 1'b0}; beat_data = data_q[63:32]; end
        default: begin beat_addr = 4'hB + {2'b00, ch_q}; beat_data = {28'b0, conf_q}; beat_last = 1'b1; end
      endcase
      2'd2: begin
        beat_rw   = 1'b0;
        beat_addr = (beat_q == 2'd0) ? 4'h1 : 4'h2;
        beat_last = (beat_q != 2'd0);
      end
      default: begin
        beat_rw   = 1'b0;
        beat_addr = data_q[3:0];
        beat_last = 1'b1;
      end
    endcase
  end

  assign issue    = (state_q == ISSUE) && !bus.iREQ_BUSY;
  // A zero count means nothing is in flight, so stray beats cannot underflow it.
  assign rsp_take = bus.iREQ_VALID && (outst_q != 2'd0);

  always_comb begin
    outst_d = outst_q;
    if (issue && !rsp_take)
      outst_d = outst_q + 2'd1;
    else if (!issue && rsp_take)
      outst_d = outst_q - 2'd1;
    if (timeout)
      outst_d = 2'd0;
  end

  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.iCMD_VALID) state_d = ISSUE;
      ISSUE:   if (issue && beat_last) state_d = WAIT;
      WAIT:    if (outst_q == 2'd0 || timeout) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.oCMD_BUSY  = (state_q != IDLE);
    bus.oREQ_VALID = issue;
    bus.oREQ_RW    = (state_q == ISSUE) ? beat_rw : 1'b0;
    bus.oREQ_ADDR  = (state_q == ISSUE) ? beat_addr : 4'h0;
    bus.oREQ_DATA  = (state_q == ISSUE) ? beat_data : 32'h0;
    bus.oRSP_VALID = (state_q == DONE);
    bus.oRSP_DATA  = rsp_data_q;
  end

  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      op_q       <= '0;
      ch_q       <= '0;
      conf_q     <= '0;
      data_q     <= '0;
      beat_q     <= '0;
      outst_q    <= '0;
      rd_idx_q   <= 1'b0;
      acc_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      outst_q <= outst_d;
      if (state_q == IDLE && bus.iCMD_VALID) begin
        op_q     <= bus.iCMD_OP;
        ch_q     <= bus.iCMD_CH;
        conf_q   <= bus.iCMD_CONF;
        data_q   <= bus.iCMD_DATA;
        beat_q   <= '0;
        rd_idx_q <= 1'b0;
        acc_q    <= '0;
      end else if (issue) begin
        beat_q <= beat_q + 2'd1;
      end
      // Only read ops (op[1]=1) keep response data; write acks are dropped.
      if (rsp_take && op_q[1]) begin
        if (rd_idx_q)
          acc_q[63:32] <= bus.iREQ_DATA;
        else
          acc_q[31:0]  <= bus.iREQ_DATA;
        rd_idx_q <= 1'b1;
      end
      if (state_q == WAIT && state_d == DONE)
        rsp_data_q <= timeout ? 64'h0 : acc_q;
    end
  end

`ifdef UTIM64_MASTER_TIMEOUT_EN
  logic [7:0] to_q;
  logic       err_q;

  assign timeout = (state_q == WAIT) && (outst_q != 2'd0) && (to_q == 8'd255);

  // Held at 0 outside WAIT so the first WAIT cycle sees 0; DONE follows 256 quiet cycles later.
  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != WAIT || bus.iREQ_VALID)
        to_q <= '0;
      else
        to_q <= to_q + 8'd1;
      if (state_q == WAIT && state_d == DONE)
        err_q <= timeout;
    end
  end

  assign bus.oRSP_ERR = (state_q == DONE) && err_q;
`else
  assign timeout      = 1'b0;
  assign bus.oRSP_ERR = 1'b0;
`endif
endmodule
